// File: rtl/force_distributor_mp.sv
// Force writeback distributor: neighbor forces stream through a FIFO, while per-filter
// reference forces sit in a NUM_FILTER x NUM_PHASE slot table that is flushed on request.
module force_distributor_mp #(
    parameter int DATA_WIDTH        = 32,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int NUM_PHASE         = 2,
    parameter int PHASE_WIDTH       = (NUM_PHASE > 1) ? $clog2(NUM_PHASE) : 1,
    parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    parameter int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH,
    parameter int WAIT_CYCLES       = 5,
    parameter int NB_FIFO_DEPTH     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_wb,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]  ref_force_x,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]  ref_force_y,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]  ref_force_z,
    input  logic [NUM_FILTER-1:0][ID_WIDTH-1:0]    ref_id,
    input  logic [NUM_FILTER-1:0][PHASE_WIDTH-1:0] ref_phase,
    input  logic [NUM_FILTER-1:0]                  ref_force_valid,
    input  logic [DATA_WIDTH-1:0]                  force_x,
    input  logic [DATA_WIDTH-1:0]                  force_y,
    input  logic [DATA_WIDTH-1:0]                  force_z,
    input  logic [ID_WIDTH-1:0]                    nb_id,
    input  logic                                   force_valid,
    input  logic                                   ready,
    output logic [WB_WIDTH-1:0]                    wb_out,
    output logic                                   wb_valid,
    output logic                                   all_ref_wb_issued,
    output logic                                   nb_fifo_full,
    output logic                                   err_nb_overflow,
    output logic                                   err_ref_drop,
    output logic [1:0]                             dbg_state
);
    localparam int NUM_SLOT = NUM_FILTER * NUM_PHASE;
    localparam int SLOT_W   = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
    localparam int AW       = $clog2(NB_FIFO_DEPTH);
    localparam int CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_WAIT   = 2'd1,
        S_WB_REF = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WB_WIDTH-1:0]  fifo_mem [NB_FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ, occ_d;
    logic                 fifo_empty, fifo_full, push, pop, nb_drop;
    logic [WB_WIDTH-1:0]  slot_data_q [NUM_SLOT];
    logic [NUM_SLOT-1:0]  slot_valid_q, slot_valid_d, slot_we;
    logic [SLOT_W-1:0]    ptr;
    logic                 any_slot, ref_drop, in_range;
    logic                 pulse_q, pulse_d, full_q, err_nb_q, err_ref_q;

    // Handshake: a word transfers on a clock edge where wb_valid & ready are both high;
    // wb_out/wb_valid never depend on ready, so a stalled word holds still until accepted.

    assign occ        = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == (AW+1)'(NB_FIFO_DEPTH));
    assign pop        = (state_q != S_WB_REF) && ready && !fifo_empty;
    assign push       = force_valid && (!fifo_full || pop);
    assign nb_drop    = force_valid && fifo_full && !pop;
    assign wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    assign occ_d      = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {nb_id, force_z, force_y, force_x};
    end

    // Slot s = phase*NUM_FILTER + f; phases outside the table are reported, not written.
    always_comb begin
        slot_we  = '0;
        ref_drop = 1'b0;
        in_range = 1'b0;
        for (int f = 0; f < NUM_FILTER; f++) begin
            if (ref_force_valid[f]) begin
                if (state_q == S_WB_REF) begin
                    ref_drop = 1'b1;
                end else begin
                    in_range = 1'b0;
                    for (int p = 0; p < NUM_PHASE; p++) begin
                        if (ref_phase[f] == PHASE_WIDTH'(p)) begin
                            in_range                   = 1'b1;
                            slot_we[p*NUM_FILTER + f]  = 1'b1;
                        end
                    end
                    if (!in_range) ref_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PHASE; p++) begin
            for (int f = 0; f < NUM_FILTER; f++) begin
                if (slot_we[p*NUM_FILTER + f])
                    slot_data_q[p*NUM_FILTER + f] <= {ref_id[f], ref_force_z[f], ref_force_y[f], ref_force_x[f]};
            end
        end
    end

    always_comb begin
        ptr      = '0;
        any_slot = |slot_valid_q;
        for (int s = NUM_SLOT - 1; s >= 0; s--) begin
            if (slot_valid_q[s]) ptr = SLOT_W'(s);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pulse_d      = 1'b0;
        slot_valid_d = slot_valid_q | slot_we;
        case (state_q)
            S_ACTIVE: begin
                if (start_wb) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (force_valid || !fifo_empty) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d = S_WB_REF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB_REF: begin
                if (any_slot) begin
                    if (ready) slot_valid_d[ptr] = 1'b0;
                end else begin
                    state_d = S_ACTIVE;
                    pulse_d = 1'b1;
                end
            end
            default: state_d = S_ACTIVE;
        endcase
    end

    always_comb begin
        wb_valid = 1'b0;
        wb_out   = '0;
        if (state_q == S_WB_REF) begin
            if (any_slot) begin
                wb_valid = 1'b1;
                wb_out   = slot_data_q[ptr];
            end
        end else if (!fifo_empty) begin
            wb_valid = 1'b1;
            wb_out   = fifo_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_ACTIVE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            slot_valid_q <= '0;
            pulse_q      <= 1'b0;
            full_q       <= 1'b0;
            err_nb_q     <= 1'b0;
            err_ref_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            slot_valid_q <= slot_valid_d;
            pulse_q      <= pulse_d;
            full_q       <= (occ_d == (AW+1)'(NB_FIFO_DEPTH));
            err_nb_q     <= err_nb_q | nb_drop;
            err_ref_q    <= err_ref_q | ref_drop;
        end
    end

    assign all_ref_wb_issued = pulse_q;
    assign nb_fifo_full      = full_q;
    assign err_nb_overflow   = err_nb_q;
    assign err_ref_drop      = err_ref_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_force_distributor_mp.sv
// Directed bench for force_distributor_mp: neighbor streaming, reference flushes,
// quiet-counter restart, dropped traffic and reset during a flush.
module tb_force_distributor_mp;
  localparam int DW = 32;
  localparam int NF = 7;
  localparam int IDW = 16;
  localparam int WBW = 112;
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_WB_REF = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_wb = 1'b0;
  logic [NF-1:0][DW-1:0] ref_force_x = '0;
  logic [NF-1:0][DW-1:0] ref_force_y = '0;
  logic [NF-1:0][DW-1:0] ref_force_z = '0;
  logic [NF-1:0][IDW-1:0] ref_id = '0;
  logic [NF-1:0][0:0] ref_phase = '0;
  logic [NF-1:0][1:0] ref_phase3 = '0;
  logic [NF-1:0] ref_force_valid = '0;
  logic [DW-1:0] force_x = '0, force_y = '0, force_z = '0;
  logic [IDW-1:0] nb_id = '0;
  logic force_valid = 1'b0;
  logic ready = 1'b0;

  logic [WBW-1:0] wb_out, wb_out3;
  logic wb_valid, all_ref_wb_issued, nb_fifo_full, err_nb_overflow, err_ref_drop;
  logic wb_valid3, all_ref_wb_issued3, nb_fifo_full3, err_nb_overflow3, err_ref_drop3;
  logic [1:0] dbg_state, dbg_state3;

  logic [WBW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  force_distributor_mp #(.NUM_PHASE(2)) dut (
    .clk(clk), .rst(rst), .start_wb(start_wb),
    .ref_force_x(ref_force_x), .ref_force_y(ref_force_y), .ref_force_z(ref_force_z),
    .ref_id(ref_id), .ref_phase(ref_phase), .ref_force_valid(ref_force_valid),
    .force_x(force_x), .force_y(force_y), .force_z(force_z), .nb_id(nb_id),
    .force_valid(force_valid), .ready(ready),
    .wb_out(wb_out), .wb_valid(wb_valid), .all_ref_wb_issued(all_ref_wb_issued),
    .nb_fifo_full(nb_fifo_full), .err_nb_overflow(err_nb_overflow),
    .err_ref_drop(err_ref_drop), .dbg_state(dbg_state)
  );

  // Three-phase instance: 2-bit phase lets the bench drive an out-of-table phase (3).
  force_distributor_mp #(.NUM_PHASE(3)) dut3 (
    .clk(clk), .rst(rst), .start_wb(start_wb),
    .ref_force_x(ref_force_x), .ref_force_y(ref_force_y), .ref_force_z(ref_force_z),
    .ref_id(ref_id), .ref_phase(ref_phase3), .ref_force_valid(ref_force_valid),
    .force_x(force_x), .force_y(force_y), .force_z(force_z), .nb_id(nb_id),
    .force_valid(force_valid), .ready(ready),
    .wb_out(wb_out3), .wb_valid(wb_valid3), .all_ref_wb_issued(all_ref_wb_issued3),
    .nb_fifo_full(nb_fifo_full3), .err_nb_overflow(err_nb_overflow3),
    .err_ref_drop(err_ref_drop3), .dbg_state(dbg_state3)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [WBW-1:0] nb_word(input int i);
    return {16'(i + 'h100), 32'('h7000 + i), 32'('h6000 + i), 32'('h5000 + i)};
  endfunction

  function automatic logic [WBW-1:0] ref_word(input int base, input int s);
    return {16'(s + 'h40), 32'(base + 'h3000 + s), 32'(base + 'h200 + s), 32'(base + 'h10 + s)};
  endfunction

  task automatic set_nb(input int i);
    nb_id = 16'(i + 'h100);
    force_z = 32'('h7000 + i);
    force_y = 32'('h6000 + i);
    force_x = 32'('h5000 + i);
    force_valid = 1'b1;
  endtask

  task automatic set_ref(input int f, input int p, input int base, input int s);
    ref_id[f] = 16'(s + 'h40);
    ref_force_z[f] = 32'(base + 'h3000 + s);
    ref_force_y[f] = 32'(base + 'h200 + s);
    ref_force_x[f] = 32'(base + 'h10 + s);
    ref_phase[f] = 1'(p);
    ref_phase3[f] = 2'(p);
  endtask

  // start_wb then quiet inputs; returns in the first WB_REF cycle
  task automatic go_flush;
    start_wb = 1'b1;
    tick;
    start_wb = 1'b0;
    repeat (6) tick;
  endtask

  task automatic test_reset;
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_out !== '0) begin errors++; $display("FAIL reset_wb_out: got %h want 0", wb_out); end
    checks++; if (all_ref_wb_issued !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", all_ref_wb_issued); end
    checks++; if (nb_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", nb_fifo_full); end
    checks++; if (err_nb_overflow !== 1'b0 || err_ref_drop !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b want 00", err_nb_overflow, err_ref_drop); end
    checks++; if (dbg_state !== ST_ACTIVE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_ACTIVE); end
    rst = 1'b1;
    tick;
    checks++; if (dbg_state !== ST_ACTIVE || wb_valid !== 1'b0) begin errors++; $display("FAIL post_reset: state %0d valid %b want 0/0", dbg_state, wb_valid); end
  endtask

  task automatic test_nb_stream;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_nb(i);
      tick;
      checks++; if (wb_valid !== 1'b1 || wb_out !== nb_word(i)) begin errors++; $display("FAIL nb_stream_%0d: got %b/%h want 1/%h", i, wb_valid, wb_out, nb_word(i)); end
    end
    force_valid = 1'b0;
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nb_stream_empty: got %b want 0", wb_valid); end
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_nb(10 + i);
      if (i < 8) exp_q.push_back(nb_word(10 + i));
      tick;
      if (i == 7) begin
        checks++; if (nb_fifo_full !== 1'b1) begin errors++; $display("FAIL nb_full_at_8: got %b want 1", nb_fifo_full); end
        checks++; if (err_nb_overflow !== 1'b0) begin errors++; $display("FAIL nb_ovf_early: got %b want 0", err_nb_overflow); end
      end
      if (i == 8) begin
        checks++; if (err_nb_overflow !== 1'b1) begin errors++; $display("FAIL nb_ovf_set: got %b want 1", err_nb_overflow); end
      end
    end
    force_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_out !== exp_q[0]) begin errors++; $display("FAIL nb_head_stalled: got %b/%h want 1/%h", wb_valid, wb_out, exp_q[0]); end
    // push into a full FIFO while it pops: accepted
    ready = 1'b1;
    set_nb(30);
    exp_q.push_back(nb_word(30));
    tick;
    void'(exp_q.pop_front());
    force_valid = 1'b0;
    checks++; if (nb_fifo_full !== 1'b1) begin errors++; $display("FAIL nb_full_push_pop: got %b want 1", nb_fifo_full); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_out !== exp_q[0]) begin errors++; $display("FAIL nb_drain_%0d: got %b/%h want 1/%h", i, wb_valid, wb_out, exp_q[0]); end
      void'(exp_q.pop_front());
      tick;
    end
    checks++; if (wb_valid !== 1'b0 || nb_fifo_full !== 1'b0) begin errors++; $display("FAIL nb_drained: valid %b full %b want 0/0", wb_valid, nb_fifo_full); end
    checks++; if (err_nb_overflow !== 1'b1) begin errors++; $display("FAIL nb_ovf_sticky: got %b want 1", err_nb_overflow); end
  endtask

  task automatic test_full_flush;
    ready = 1'b1;
    for (int f = 0; f < NF; f++) set_ref(f, 0, 0, f);
    ref_force_valid = '1;
    tick;
    for (int f = 0; f < NF; f++) set_ref(f, 1, 0, NF + f);
    tick;
    ref_force_valid = '0;
    start_wb = 1'b1;
    tick;
    start_wb = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL flush_wait_%0d: got %0d want %0d", i, dbg_state, ST_WAIT); end
      tick;
    end
    checks++; if (dbg_state !== ST_WB_REF) begin errors++; $display("FAIL flush_enter: got %0d want %0d", dbg_state, ST_WB_REF); end
    for (int s = 0; s < 14; s++) begin
      checks++; if (wb_valid !== 1'b1 || wb_out !== ref_word(0, s)) begin errors++; $display("FAIL flush_slot_%0d: got %b/%h want 1/%h", s, wb_valid, wb_out, ref_word(0, s)); end
      tick;
    end
    checks++; if (wb_valid !== 1'b0 || dbg_state !== ST_WB_REF || all_ref_wb_issued !== 1'b0) begin errors++; $display("FAIL flush_tail: valid %b state %0d pulse %b want 0/2/0", wb_valid, dbg_state, all_ref_wb_issued); end
    tick;
    checks++; if (dbg_state !== ST_ACTIVE || all_ref_wb_issued !== 1'b1) begin errors++; $display("FAIL flush_done: state %0d pulse %b want 0/1", dbg_state, all_ref_wb_issued); end
    tick;
    checks++; if (all_ref_wb_issued !== 1'b0) begin errors++; $display("FAIL flush_pulse_width: got %b want 0", all_ref_wb_issued); end
  endtask

  task automatic test_sparse_flush;
    logic [WBW-1:0] exp_w [4];
    logic rdy_pat [4];
    exp_w[0] = ref_word('h100, 3); exp_w[1] = ref_word('h100, 3);
    exp_w[2] = ref_word('h100, 9); exp_w[3] = ref_word('h100, 9);
    rdy_pat[0] = 1'b0; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    ready = 1'b1;
    set_ref(3, 0, 'h100, 3);
    set_ref(2, 1, 'h100, 9);
    ref_force_valid = 7'b0001100;
    tick;
    ref_force_valid = '0;
    go_flush;
    for (int c = 0; c < 4; c++) begin
      checks++; if (wb_valid !== 1'b1 || wb_out !== exp_w[c]) begin errors++; $display("FAIL sparse_c%0d: got %b/%h want 1/%h", c, wb_valid, wb_out, exp_w[c]); end
      ready = rdy_pat[c];
      // neighbor pushes during the flush must land but not be drained yet
      if (c < 2) set_nb(40 + c);
      else force_valid = 1'b0;
      tick;
    end
    checks++; if (wb_valid !== 1'b0 || dbg_state !== ST_WB_REF || all_ref_wb_issued !== 1'b0) begin errors++; $display("FAIL sparse_tail: valid %b state %0d pulse %b want 0/2/0", wb_valid, dbg_state, all_ref_wb_issued); end
    tick;
    checks++; if (dbg_state !== ST_ACTIVE || all_ref_wb_issued !== 1'b1) begin errors++; $display("FAIL sparse_done: state %0d pulse %b want 0/1", dbg_state, all_ref_wb_issued); end
    checks++; if (wb_valid !== 1'b1 || wb_out !== nb_word(40)) begin errors++; $display("FAIL sparse_nb0: got %b/%h want 1/%h", wb_valid, wb_out, nb_word(40)); end
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_out !== nb_word(41)) begin errors++; $display("FAIL sparse_nb1: got %b/%h want 1/%h", wb_valid, wb_out, nb_word(41)); end
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sparse_nb_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_quiet_restart;
    ready = 1'b1;
    start_wb = 1'b1;
    tick;
    start_wb = 1'b0;
    repeat (3) tick;
    set_nb(50);
    tick;
    force_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_out !== nb_word(50) || dbg_state !== ST_WAIT) begin errors++; $display("FAIL quiet_nb: got %b/%h st %0d want 1/%h st 1", wb_valid, wb_out, dbg_state, nb_word(50)); end
    tick;
    for (int i = 0; i < 6; i++) begin
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL quiet_wait_%0d: got %0d want %0d", i, dbg_state, ST_WAIT); end
      tick;
    end
    checks++; if (dbg_state !== ST_WB_REF || wb_valid !== 1'b0) begin errors++; $display("FAIL quiet_empty_flush: state %0d valid %b want 2/0", dbg_state, wb_valid); end
    tick;
    checks++; if (dbg_state !== ST_ACTIVE || all_ref_wb_issued !== 1'b1) begin errors++; $display("FAIL quiet_done: state %0d pulse %b want 0/1", dbg_state, all_ref_wb_issued); end
    tick;
  endtask

  task automatic test_ref_drop;
    checks++; if (err_ref_drop !== 1'b0 || err_ref_drop3 !== 1'b0) begin errors++; $display("FAIL drop_clean: got %b%b want 00", err_ref_drop, err_ref_drop3); end
    set_ref(4, 0, 'h200, 4);
    ref_phase3[4] = 2'd3;
    ref_force_valid = 7'b0010000;
    tick;
    ref_force_valid = '0;
    checks++; if (err_ref_drop3 !== 1'b1 || err_ref_drop !== 1'b0) begin errors++; $display("FAIL drop_phase_range: dut3 %b dut %b want 1/0", err_ref_drop3, err_ref_drop); end
    set_ref(0, 0, 'h200, 0);
    ref_force_valid = 7'b0000001;
    tick;
    ref_force_valid = '0;
    ready = 1'b0;
    go_flush;
    checks++; if (wb_valid !== 1'b1 || wb_out !== ref_word('h200, 0)) begin errors++; $display("FAIL drop_first: got %b/%h want 1/%h", wb_valid, wb_out, ref_word('h200, 0)); end
    set_ref(0, 0, 'h999, 0);
    set_ref(1, 0, 'h999, 1);
    ref_force_valid = 7'b0000011;
    tick;
    ref_force_valid = '0;
    checks++; if (wb_out !== ref_word('h200, 0)) begin errors++; $display("FAIL drop_slot_kept: got %h want %h", wb_out, ref_word('h200, 0)); end
    checks++; if (err_ref_drop !== 1'b1) begin errors++; $display("FAIL drop_in_flush: got %b want 1", err_ref_drop); end
    ready = 1'b1;
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_out !== ref_word('h200, 4)) begin errors++; $display("FAIL drop_second: got %b/%h want 1/%h", wb_valid, wb_out, ref_word('h200, 4)); end
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drop_no_slot1: got %b want 0", wb_valid); end
    tick;
    checks++; if (all_ref_wb_issued !== 1'b1 || dbg_state !== ST_ACTIVE) begin errors++; $display("FAIL drop_done: pulse %b state %0d want 1/0", all_ref_wb_issued, dbg_state); end
    tick;
  endtask

  task automatic test_reset_mid_flush;
    ready = 1'b1;
    for (int f = 0; f < NF; f++) set_ref(f, 0, 'h300, f);
    ref_force_valid = '1;
    tick;
    for (int f = 0; f < NF; f++) set_ref(f, 1, 'h300, NF + f);
    tick;
    ref_force_valid = '0;
    go_flush;
    for (int i = 0; i < 5; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_out !== ref_word('h300, i)) begin errors++; $display("FAIL midrst_word_%0d: got %b/%h want 1/%h", i, wb_valid, wb_out, ref_word('h300, i)); end
      tick;
    end
    rst = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_out !== '0) begin errors++; $display("FAIL midrst_outs: got %b/%h want 0/0", wb_valid, wb_out); end
    checks++; if (all_ref_wb_issued !== 1'b0 || nb_fifo_full !== 1'b0) begin errors++; $display("FAIL midrst_flags: pulse %b full %b want 0/0", all_ref_wb_issued, nb_fifo_full); end
    checks++; if (err_nb_overflow !== 1'b0 || err_ref_drop !== 1'b0) begin errors++; $display("FAIL midrst_errs: got %b%b want 00", err_nb_overflow, err_ref_drop); end
    checks++; if (dbg_state !== ST_ACTIVE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_ACTIVE); end
    tick;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (all_ref_wb_issued !== 1'b0 || dbg_state !== ST_ACTIVE || wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_%0d: pulse %b state %0d valid %b want 0/0/0", i, all_ref_wb_issued, dbg_state, wb_valid); end
    end
    go_flush;
    checks++; if (dbg_state !== ST_WB_REF || wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_table_empty: state %0d valid %b want 2/0", dbg_state, wb_valid); end
    tick;
    checks++; if (all_ref_wb_issued !== 1'b1 || dbg_state !== ST_ACTIVE) begin errors++; $display("FAIL midrst_flush_done: pulse %b state %0d want 1/0", all_ref_wb_issued, dbg_state); end
    tick;
  endtask

  initial begin
    test_reset;
    test_nb_stream;
    test_full_flush;
    test_sparse_flush;
    test_quiet_restart;
    test_ref_drop;
    test_reset_mid_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
